// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared constants, state type and priority helper for the request arbiter
package arb_pkg;

  localparam int NREQ = 4;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Index of the highest set bit; 0 when the vector is empty (callers gate with |v).
  function automatic logic [1:0] enc_hi4(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[3])      idx = 2'd3;
    else if (v[2]) idx = 2'd2;
    else if (v[1]) idx = 2'd1;
    return idx;
  endfunction

endpackage

// File: rtl/pri_pick4.sv
// rtl/pri_pick4.sv - combinational winner pick, fixed priority or round-robin
// Ports:
//   cand      in  4  candidate request vector
//   mode      in  1  MODE_FIXED / MODE_RR
//   last      in  2  previous winner; round-robin search starts at last+1
//   win_id    out 2  index of the winner
//   win_valid out 1  any candidate present
module pri_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] cand,
  input  logic            mode,
  input  logic [1:0]      last,
  output logic [1:0]      win_id,
  output logic            win_valid
);

  logic [NREQ-1:0] rot;
  logic [1:0]      base;
  logic [1:0]      idx;
  logic [1:0]      hi;
  logic [1:0]      rr_id;

  // Rotate so that requester last+1 lands on bit 3 (highest priority), last+2 on
  // bit 2 and so on; the fixed encoder then finds the first in search order.
  always_comb begin
    rot  = '0;
    idx  = 2'd0;
    base = last + 2'd1;
    for (int k = 0; k < NREQ; k++) begin
      idx = base + k[1:0];
      rot[NREQ-1-k] = cand[idx];
    end
    hi    = enc_hi4(rot);
    rr_id = base + (2'd3 - hi);
  end

  assign win_valid = |cand;
  assign win_id    = (mode == MODE_RR) ? rr_id : enc_hi4(cand);

endmodule

// File: rtl/req_arbiter.sv
// rtl/req_arbiter.sv - four-requester arbiter with hold limit and registered grant
// Ports:
//   clk       in  1  rising-edge clock
//   rst_n     in  1  synchronous active-low reset
//   req       in  4  level-sensitive request vector
//   mode      in  1  0 fixed priority (bit 3 highest), 1 round-robin
//   gnt       out 4  one-hot grant, zero when idle
//   gnt_id    out 2  index of granted requester, zero when idle
//   gnt_valid out 1  grant active
module req_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            mode,
  output logic [NREQ-1:0] gnt,
  output logic [1:0]      gnt_id,
  output logic            gnt_valid
);

  localparam int             HW   = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0]  HMAX = HW'(MAX_HOLD);

  arb_state_t      state, state_n;
  logic [1:0]      own, own_n;
  logic [1:0]      last, last_n;
  logic [HW-1:0]   hcnt, hcnt_n;

  logic [NREQ-1:0] own_mask;
  logic            own_req;
  logic            others;
  logic            expire;
  logic [NREQ-1:0] cand;
  logic [1:0]      win_id;
  logic            win_valid;

  assign own_mask = NREQ'(1) << own;
  assign own_req  = req[own];
  assign others   = |(req & ~own_mask);
  // hcnt saturates at HMAX, so reaching it with a live owner and a competitor is expiry.
  assign expire   = (state == ARB_GRANT) && own_req && (hcnt == HMAX) && others;
  // A release re-arbitrates over everyone, including a re-requesting owner.
  assign cand     = expire ? (req & ~own_mask) : req;

  pri_pick4 u_pick (
    .cand      (cand),
    .mode      (mode),
    .last      (last),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  always_comb begin
    state_n = state;
    own_n   = own;
    last_n  = last;
    hcnt_n  = hcnt;
    case (state)
      ARB_IDLE: begin
        if (win_valid) begin
          state_n = ARB_GRANT;
          own_n   = win_id;
          last_n  = win_id;
          hcnt_n  = HW'(1);
        end
      end
      ARB_GRANT: begin
        if (own_req && !expire) begin
          if (hcnt != HMAX) hcnt_n = hcnt + HW'(1);
        end else if (win_valid) begin
          own_n  = win_id;
          last_n = win_id;
          hcnt_n = HW'(1);
        end else begin
          state_n = ARB_IDLE;
          hcnt_n  = '0;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ARB_IDLE;
      own       <= 2'd0;
      last      <= 2'd3;
      hcnt      <= '0;
      gnt       <= '0;
      gnt_id    <= 2'd0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_n;
      own       <= own_n;
      last      <= last_n;
      hcnt      <= hcnt_n;
      // Outputs are registered from next-state so they line up with the new owner.
      gnt_valid <= (state_n == ARB_GRANT);
      gnt_id    <= (state_n == ARB_GRANT) ? own_n : 2'd0;
      gnt       <= (state_n == ARB_GRANT) ? (NREQ'(1) << own_n) : '0;
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// tb/tb_req_arbiter.sv - scoreboard bench for req_arbiter against a behavioural model
module tb_req_arbiter;

  localparam int MH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0;
  logic       mode = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;

  always #5 clk = ~clk;

  req_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .mode      (mode),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid)
  );

  typedef struct {
    logic [3:0] g;
    logic [1:0] id;
    logic       v;
  } exp_t;

  exp_t expq[$];
  exp_t me;
  int   total = 0;
  int   bad   = 0;
  int   ncyc  = 0;

  // Model state: owner (-1 when idle), last winner, length of the current grant run.
  int m_own  = -1;
  int m_last = 3;
  int m_run  = 0;

  function automatic int pick(logic [3:0] c, logic md, int lst);
    int j;
    if (!md) begin
      for (int i = 3; i >= 0; i--) if (c[i]) return i;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        j = (lst + k) % 4;
        if (c[j]) return j;
      end
    end
    return -1;
  endfunction

  task automatic model(input logic [3:0] r, input logic md, input logic rn);
    int w;
    logic [3:0] oth;
    if (!rn) begin
      m_own = -1; m_last = 3; m_run = 0;
    end else if (m_own < 0) begin
      w = pick(r, md, m_last);
      if (w >= 0) begin m_own = w; m_last = w; m_run = 1; end
    end else if (r[m_own]) begin
      oth = r & ~(4'b1 << m_own);
      if (m_run < MH || oth == 4'b0) begin
        if (m_run < MH) m_run++;
      end else begin
        w = pick(oth, md, m_last);
        m_own = w; m_last = w; m_run = 1;
      end
    end else begin
      w = pick(r, md, m_last);
      if (w >= 0) begin m_own = w; m_last = w; m_run = 1; end
      else begin m_own = -1; m_run = 0; end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic md, input logic rn);
    exp_t e;
    req = r; mode = md; rst_n = rn;
    model(r, md, rn);
    e.v  = (m_own >= 0);
    e.id = e.v ? 2'(m_own) : 2'd0;
    e.g  = e.v ? 4'(1 << m_own) : 4'd0;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic dcheck(input string nm, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      me = expq.pop_front();
      ncyc++;
      total++;
      if ({gnt, gnt_id, gnt_valid} !== {me.g, me.id, me.v}) begin
        bad++;
        $display("FAIL scoreboard cycle %0d: got gnt=%b id=%0d v=%b want gnt=%b id=%0d v=%b",
                 ncyc, gnt, gnt_id, gnt_valid, me.g, me.id, me.v);
      end
    end
  end

  logic [3:0] hist[40];
  int         n_a, n_b, errs;
  logic [3:0] rr;
  logic       md_r;

  initial begin
    // reset with all requests asserted
    repeat (3) step(4'b1111, 1'b0, 1'b0);
    dcheck("reset_gnt", 8'(gnt), 8'h0);
    dcheck("reset_valid", 8'(gnt_valid), 8'h0);
    step(4'b1111, 1'b0, 1'b1);
    dcheck("first_fixed_gnt", 8'(gnt), 8'h8);

    // fixed priority, release switch without gap, then idle
    step(4'b0110, 1'b0, 1'b1);
    dcheck("fixed_id2", 8'(gnt_id), 8'd2);
    step(4'b0010, 1'b0, 1'b1);
    dcheck("fixed_switch", 8'(gnt), 8'h2);
    step(4'b0000, 1'b0, 1'b1);
    dcheck("fixed_idle", 8'(gnt_valid), 8'h0);

    // round-robin rotation 0,1,2,3,0 with each owner dropping for one cycle
    step(4'b1111, 1'b1, 1'b0);
    step(4'b1111, 1'b1, 1'b1);
    dcheck("rr_id_start", 8'(gnt_id), 8'd0);
    for (int k = 1; k <= 4; k++) begin
      step(4'b1111 & ~(4'b1 << ((k - 1) % 4)), 1'b1, 1'b1);
      dcheck("rr_id_seq", 8'(gnt_id), 8'(k % 4));
      if (k < 4) step(4'b1111, 1'b1, 1'b1);
    end

    // hold expiry with two competitors in fixed mode
    step(4'b0000, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(4'b1001, 1'b0, 1'b1);
      hist[i] = gnt;
    end
    n_a = 0;
    while (n_a < 40 && hist[n_a] == 4'b1000) n_a++;
    n_b = 0;
    while (n_a + n_b < 40 && hist[n_a + n_b] == 4'b0001) n_b++;
    dcheck("hold_run_bit3", 8'(n_a), 8'(MH));
    dcheck("hold_run_bit0", 8'(n_b), 8'(MH));
    dcheck("hold_back_bit3", 8'(hist[2 * MH]), 8'h8);

    // sole requester never expires, mode flip mid-grant is ignored
    step(4'b0000, 1'b0, 1'b0);
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step(4'b0100, (i >= 10), 1'b1);
      if (gnt !== 4'b0100) errs++;
    end
    dcheck("sole_hold_errs", 8'(errs), 8'd0);

    // reset during a grant, then round-robin restarts at requester 0
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b1);
    step(4'b1111, 1'b1, 1'b0);
    dcheck("midreset_gnt", 8'(gnt), 8'h0);
    step(4'b1111, 1'b1, 1'b1);
    dcheck("midreset_rr_id", 8'(gnt_id), 8'd0);
    dcheck("midreset_rr_valid", 8'(gnt_valid), 8'd1);

    // randomized traffic; requests often held so expiries occur
    rr   = 4'b0;
    md_r = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) rr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) md_r = ~md_r;
      step(rr, md_r, ($urandom_range(0, 199) != 0));
    end

    for (int i = 0; i < 10 && expq.size() > 0; i++) @(negedge clk);
    #1;
    total++;
    if (expq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", expq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/req_arbiter.md
# req_arbiter

Four-requester arbiter that shares one downstream resource, such as a bus port or execution unit, between requesters `req[3:0]`. It supports fixed priority (bit 3 highest, the same ordering as the team's 4-bit priority encoder) and round-robin. A grant is held while its requester keeps `req` high, bounded by a hold limit. Outputs are registered. The block sits between the requesters and the shared resource's select mux.

## Interface
Parameters:
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while other requests are pending. Legal range is ≥1.

Ports:
- `clk`  in  1  sole clock; all logic is on the rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  4  request vector; level-sensitive
- `mode`  in  1  0 = fixed priority, 1 = round-robin
- `gnt`  out  4  one-hot grant, registered; all-zero when idle
- `gnt_id`  out  2  binary index of the granted requester; 0 when idle
- `gnt_valid`  out  1  high when `gnt` is non-zero

## Operation
- **States:** IDLE and GRANT, plus an owner register `own[1:0]`, a last-winner pointer `last[1:0]` and a hold counter `hcnt`.
- **Arbitration point:** any edge in IDLE, and any GRANT edge where a release or an expiry occurs.
- **Fixed mode pick:** highest set bit of the candidate vector.
- **Round-robin pick:** first set bit searching `last+1`, `last+2`, `last+3`, `last` (mod 4).
- **IDLE:**
  - If `req != 0`, pick a winner, go to GRANT, set `own = winner`, `last = winner`, `hcnt = 1`.
  - Otherwise stay in IDLE.
- **GRANT, continue:** `req[own] = 1` and (`hcnt < MAX_HOLD` or no other request). Stay and increment `hcnt`, saturating at `MAX_HOLD`.
- **GRANT, release:** `req[own] = 0`.
  - Re-arbitrate over `req`.
  - If there is a winner, switch to it directly with no dead cycle and set `hcnt = 1`.
  - Otherwise go to IDLE.
- **GRANT, expiry:** `req[own] = 1`, `hcnt == MAX_HOLD`, and another request is pending.
  - Re-arbitrate over `req` with the owner bit masked.
  - Switch to that winner with `hcnt = 1`.
- **Sole requester:** never expires; holds indefinitely.
- **Mode changes:** `mode` is sampled only at arbitration points. A mode change mid-grant does not disturb the current owner.
- **Pointer update:** `last` updates only on a new grant, in both modes. Fixed mode ignores `last`, but it is still tracked.
- **Outputs:** `gnt`, `gnt_id` and `gnt_valid` are always mutually consistent: `gnt = 1 << gnt_id` when valid, and 0 when not valid.

## Timing
- **Reset values:** `rst_n` low at an edge forces `gnt = 0`, `gnt_id = 0`, `gnt_valid = 0`, state IDLE, `own = 0`, `last = 3` (so the first round-robin search starts at 0), `hcnt = 0`.
- **Reset mid-grant:** drops the grant on the next edge.
- **Grant latency:** `req` sampled at edge t produces `gnt` valid after edge t, i.e. in the cycle following the request (1 cycle).
- **Release latency:** the owner's `req` low at edge t means `gnt` is removed or switched after edge t. The resource sees the old owner for exactly the cycles its `req` was sampled high.
- **Hold bound:** with competition, one owner holds `gnt` for at most `MAX_HOLD` consecutive cycles.
- **Simultaneous release and new requests:** release takes precedence; the owner is not masked, so it may immediately win again if it re-requests.
- **Counter width:** `hcnt` is `$clog2(MAX_HOLD+1)` bits and saturates, never wraps.
- **Round-robin wrap:** after `last = 3` the search starts at 0.

## Structure
- **Shared package `arb_pkg`:**
  - `NREQ = 4`
  - `MODE_FIXED = 1'b0`, `MODE_RR = 1'b1`
  - state enum `{ARB_IDLE, ARB_GRANT}`
- **Sub-module `pri_pick4`:** combinational; inputs candidate vector, `mode`, `last`; outputs `win_id[1:0]`, `win_valid`. Round-robin is implemented as rotate → fixed-priority encode → un-rotate.
- **`req_arbiter`:** holds the FSM, counter and output registers.

## Test plan
- **Reset:** hold `rst_n` = 0 with `req = 4'b1111` → `gnt = 0`, `gnt_valid = 0`. Release reset → `gnt = 4'b1000` (fixed mode) one cycle later.
- **Fixed priority:** `mode = 0`, `req = 4'b0110` → `gnt_id = 2`. Drop bit 2 → next cycle `gnt = 4'b0010` with no idle gap. Then set `req = 0` → `gnt_valid = 0` next cycle.
- **Round-robin rotation:** `mode = 1`, `req = 4'b1111`, each owner dropping its `req` for one cycle after grant → `gnt_id` sequence 0, 1, 2, 3, 0.
- **Hold expiry:** `MAX_HOLD = 8`, `mode = 0`, `req = 4'b1001` held constant → bit 3 granted for exactly 8 cycles, then `gnt = 4'b0001` for 8 cycles, then back to bit 3.
- **Sole requester:** `req = 4'b0100` held for 20 cycles → `gnt = 4'b0100` for all 20 with no expiry. Flip `mode` mid-grant → no change.
- **Reset mid-operation:** `rst_n` low for one cycle during a grant → `gnt = 0` the next cycle. The next round-robin grant with `req = 4'b1111` goes to requester 0.
